// File: rtl/sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package sub_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Width of the bit counter for the default width.
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Control states: IDLE waits for start, RUN processes one bit per edge,
    // DONE presents the one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor_8.sv
// Bit-serial subtractor: diff = x - y - borrow_in, LSB first, one bit per
// clock through a single full_subtractor cell.
//
// Handshake: start is a request that is accepted on a rising edge whenever
// the block is not busy (state IDLE or DONE); x, y and borrow_in are sampled
// on that same edge and may change afterwards. busy is high while bits are
// being processed and start is ignored then. done pulses for exactly one
// cycle when diff/borrow_out/overflow take their new values; those outputs
// hold until the next operation completes.
module serial_subtractor_8
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output state_t           dbg_state
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // Control state and bit counter.
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    // Operand shift registers and running borrow.
    logic [WIDTH-1:0] r_x_sh;
    logic [WIDTH-1:0] r_y_sh;
    logic             r_borrow;

    // Low-order difference bits collected so far; the final bit comes
    // straight from the cell on the last edge.
    logic [WIDTH-2:0] r_acc;

    // Architecturally visible results.
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;

    // Decoded control.
    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_done;

    // Bit cell connections.
    logic w_a;
    logic w_b;
    logic w_d;
    logic w_bout;

    assign w_a = r_x_sh[0];
    assign w_b = r_y_sh[0];

    full_subtractor u_cell (
        .a   (w_a),
        .b   (w_b),
        .bin (r_borrow),
        .d   (w_d),
        .bout(w_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; DONE accepts a new start just like IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_run    = 1'b0;
        w_last   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand load on accept, then shift right one bit per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_sh   <= '0;
            r_y_sh   <= '0;
            r_borrow <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_x_sh   <= x;
            r_y_sh   <= y;
            r_borrow <= borrow_in;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_run) begin
            r_x_sh   <= {1'b0, r_x_sh[WIDTH-1:1]};
            r_y_sh   <= {1'b0, r_y_sh[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_acc    <= {w_d, r_acc[WIDTH-2:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Results change only on the final RUN edge, so no partial value leaks out.
    // At that edge the cell inputs are the original operand MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_last) begin
            r_diff       <= {w_d, r_acc};
            r_borrow_out <= w_bout;
            r_overflow   <= (w_a ^ w_b) & (w_a ^ w_d);
        end
    end

    assign busy       = w_run;
    assign done       = w_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule : serial_subtractor_8

// File: tb/tb_serial_subtractor_8.sv
// Self-checking bench for serial_subtractor_8 against an arithmetic model.
module tb_serial_subtractor_8;
    import sub_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    state_t       dbg_state;

    always #5 clk = ~clk;

    serial_subtractor_8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {borrow_out, overflow, diff} per accepted operation.
    logic [W+1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Plain integer arithmetic: unsigned result for diff/borrow, signed range
    // test for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
        int           ud;
        int           sd;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        ud = int'(a) - int'(b) - int'(bi);
        d  = ud[W-1:0];
        bo = (ud < 0);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return {bo, ov, d};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one operation for a single edge; returns on the falling edge
    // just after the accepting edge, with inputs scrambled.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic bi);
        @(negedge clk);
        x = xa;
        y = ya;
        borrow_in = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        borrow_in = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for done; lat counts falling edges from the call.
    task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
        lat = 0;
        busy_cnt = 0;
        ok = 1'b0;
        while (lat <= 3 * W) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, borrow_out, overflow, diff} !== '0) begin
            $display("FAIL reset_outputs got busy=%b done=%b diff=%h bo=%b ov=%b exp all 0",
                     busy, done, diff, borrow_out, overflow);
        end else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) begin
            $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] tx[5] = '{8'h50, 8'h20, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0] ty[5] = '{8'h20, 8'h50, 8'h01, 8'hFF, 8'h00};
        logic         tb_[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        int bcnt;
        bit ok;
        logic [W+1:0] e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model(tx[i], ty[i], tb_[i]));
            start_op(tx[i], ty[i], tb_[i]);
            wait_done(lat, bcnt, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || lat != W || bcnt != W) begin
                $display("FAIL directed_latency[%0d] got ok=%0d lat=%0d busy=%0d exp lat=%0d busy=%0d",
                         i, ok, lat, bcnt, W, W);
            end else n_pass++;
            n_checks++;
            if ({borrow_out, overflow, diff} !== e) begin
                $display("FAIL directed_result[%0d] got bo=%b ov=%b diff=%h exp bo=%b ov=%b diff=%h",
                         i, borrow_out, overflow, diff, e[W+1], e[W], e[W-1:0]);
            end else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                $display("FAIL directed_done_pulse[%0d] got done=%b exp 0", i, done);
            end else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [W+1:0] e;
        int lat;
        int bcnt;
        bit ok;
        int bad;
        e = model(8'h00, 8'h00, 1'b1);
        start_op(8'h00, 8'h00, 1'b1);
        wait_done(lat, bcnt, ok);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({borrow_out, overflow, diff} !== e || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (!ok || bad != 0) begin
            $display("FAIL hold_stable got ok=%0d bad_cycles=%0d diff=%h exp 0 bad, diff=%h",
                     ok, bad, diff, e[W-1:0]);
        end else n_pass++;
    endtask

    // Ignored start during RUN, then back-to-back start in the DONE cycle.
    task automatic test_handshake();
        int lat;
        int bcnt;
        bit ok;
        logic [W+1:0] e;
        exp_q.push_back(model(8'h10, 8'h01, 1'b0));
        start_op(8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        x = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != W - 4) begin
            $display("FAIL ignore_latency got ok=%0d lat=%0d exp %0d", ok, lat, W - 4);
        end else n_pass++;
        n_checks++;
        if ({borrow_out, overflow, diff} !== e) begin
            $display("FAIL ignore_result got diff=%h bo=%b ov=%b exp diff=%h bo=%b ov=%b",
                     diff, borrow_out, overflow, e[W-1:0], e[W+1], e[W]);
        end else n_pass++;
        // Now in the done cycle: request the next operation immediately.
        exp_q.push_back(model(8'h09, 8'h03, 1'b0));
        x = 8'h09;
        y = 8'h03;
        borrow_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'hFF;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL b2b_accept got busy=%b exp 1", busy);
        end else n_pass++;
        wait_done(lat, bcnt, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != W || {borrow_out, overflow, diff} !== e) begin
            $display("FAIL b2b_result got ok=%0d lat=%0d diff=%h exp lat=%0d diff=%h",
                     ok, lat, diff, W, e[W-1:0]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int bcnt;
        bit ok;
        bit saw_done;
        logic [W+1:0] e;
        start_op(8'h50, 8'h20, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, borrow_out, overflow, diff} !== '0 || dbg_state !== IDLE) begin
            $display("FAIL midreset_clear got busy=%b done=%b diff=%h bo=%b ov=%b st=%0d exp all 0",
                     busy, done, diff, borrow_out, overflow, dbg_state);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            $display("FAIL midreset_no_done got activity=1 exp 0");
        end else n_pass++;
        exp_q.push_back(model(8'h05, 8'h02, 1'b0));
        start_op(8'h05, 8'h02, 1'b0);
        wait_done(lat, bcnt, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != W || {borrow_out, overflow, diff} !== e) begin
            $display("FAIL midreset_restart got ok=%0d lat=%0d diff=%h exp lat=%0d diff=%h",
                     ok, lat, diff, W, e[W-1:0]);
        end else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        int bcnt;
        bit ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic bi;
        logic [W+1:0] e;
        for (int i = 0; i < 40; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            bi = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, bi));
            start_op(a, b, bi);
            // Occasionally poke start while busy; it must be ignored.
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(lat, bcnt, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || {borrow_out, overflow, diff} !== e) begin
                $display("FAIL random[%0d] %h-%h-%b got ok=%0d bo=%b ov=%b diff=%h exp bo=%b ov=%b diff=%h",
                         i, a, b, bi, ok, borrow_out, overflow, diff, e[W+1], e[W], e[W-1:0]);
            end else n_pass++;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_subtractor_8

// File: doc/serial_subtractor_8.md
Name: serial_subtractor_8

Overview:
- Registered, bit-serial 8-bit subtractor: computes diff = x - y - borrow_in, one bit per clock, LSB first, through a single 1-bit full-subtractor cell.
- It is the inverse arithmetic counterpart of the team's ripple-carry 8-bit adder and sits beside it in the arithmetic lab datapath.
- A start/busy/done handshake wraps the block so it can be driven by a control FSM.
- It trades latency (8 cycles) for area (one bit cell).

Parameters:
- WIDTH, 8, operand and result width in bits; the bit counter is $clog2(WIDTH) bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- x  input  WIDTH  minuend; sampled on the accepting edge.
- y  input  WIDTH  subtrahend; sampled on the accepting edge.
- borrow_in  input  1  incoming borrow; sampled on the accepting edge.
- busy  output  1  high while the bit-serial operation runs.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  difference, valid from done and held until the next accepted start.
- borrow_out  output  1  final borrow out of the MSB (unsigned x < y + borrow_in).
- overflow  output  1  signed (two's-complement) overflow of the subtraction.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0; busy=0, done=0, diff=0, borrow_out=0, overflow=0; internal operand and borrow registers cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, latch x, y and borrow_in into shift/borrow registers, counter=0, go to RUN.
  - RUN: each edge computes bit[counter] from x_sh[0], y_sh[0] and the borrow register. Shift the operands right, shift the difference bit into the MSB of the diff register, update the borrow register, then counter++. When counter==WIDTH-1 on that edge, go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE unconditionally. start=1 in this cycle is accepted exactly as in IDLE (next state RUN).
- Latency: start accepted at edge E0; busy=1 after E0 through E(WIDTH); done=1 in the cycle after E(WIDTH), i.e. WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+1 cycles.
- busy = (state==RUN). start while busy=1 is ignored, with no effect on the operation in progress.
- Bit cell:
  - d = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- Result registers:
  - borrow_out takes the borrow produced by the MSB step.
  - overflow = (x[MSB]^y[MSB]) & (x[MSB]^diff[MSB]), using the latched operand MSBs; registered together with the final bit.
  - diff, borrow_out and overflow update only on the final RUN edge. Between operations they hold their values, with no partial results visible outside RUN.
- Wrap-around: modular WIDTH-bit result; 0x00-0x01 = 0xFF with borrow_out=1.
- Reset mid-operation: aborts immediately to reset values; no done is produced; the next start begins a fresh operation.
- Inputs x/y/borrow_in may change freely after the accepting edge.

Decomposition:
- Shared package sub_pkg:
  - WIDTH default constant
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - counter width constant
- Sub-module full_subtractor: purely combinational ports a, b, bin, d, bout, instantiated once.
- The top level holds the FSM, counter, shift registers and result registers.

Test Plan:
- x=0x50, y=0x20, borrow_in=0, start pulse -> busy for 8 cycles, done exactly 8 cycles after the accepting edge; diff=0x30, borrow_out=0, overflow=0.
- x=0x20, y=0x50, borrow_in=0 -> diff=0xD0, borrow_out=1, overflow=0.
- x=0x80, y=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, overflow=1. Also x=0x7F, y=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- x=0x00, y=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0. Results held stable for 20 idle cycles afterwards.
- Handshake sequence:
  - Start x=0x10, y=0x01.
  - Pulse start with x=0xAA during RUN -> ignored; result is still 0x0F.
  - Start x=0x09, y=0x03 in the done cycle -> accepted back-to-back; diff=0x06 after 8 more cycles.
- Drop rst_n asynchronously mid-clock after 4 RUN edges -> busy, done, diff, borrow_out and overflow go to 0 immediately; no done pulse follows. After release, a new start 0x05-0x02 gives 0x03.
